// File: rtl/pwm_multi_ch_pkg.sv
// Shared definitions for the multi-channel PWM: default geometry and mode encoding.
package pwm_multi_ch_pkg;

    localparam int PWM_N_CH       = 4;
    localparam int PWM_CNT_W      = 8;
    localparam int PWM_PS_W       = 8;
    localparam int PWM_DEF_PERIOD = 100;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

endpackage

// File: rtl/pwm_multi_ch_compare_ch.sv
// One PWM channel: duty compare, polarity inversion and the registered output pin.
module pwm_compare_ch
    import pwm_multi_ch_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic [CNT_W-1:0] I_idx,
    input  logic [CNT_W-1:0] I_duty,
    input  logic             I_pol,
    input  logic             I_off,
    output logic             O_pwm
);

    logic raw;
    logic pwm_d, pwm_q;

    always_comb begin
        raw   = ~I_off & (I_idx < I_duty);
        pwm_d = raw ^ I_pol;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) pwm_q <= 1'b0;
        else       pwm_q <= pwm_d;
    end

    assign O_pwm = pwm_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM: shared prescaler and edge/center period counter, shadowed config
// that only becomes active at period boundaries (or immediately while disabled).
module pwm_multi_ch
    import pwm_multi_ch_pkg::*;
#(
    parameter int N_CH       = PWM_N_CH,
    parameter int CNT_W      = PWM_CNT_W,
    parameter int PS_W       = PWM_PS_W,
    parameter int DEF_PERIOD = PWM_DEF_PERIOD
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_en,
    input  logic [PS_W-1:0]       I_prescale,
    input  logic [CNT_W-1:0]      I_period,
    input  logic [N_CH*CNT_W-1:0] I_duty,
    input  logic                  I_center,
    input  logic [N_CH-1:0]       I_polarity,
    input  logic                  I_update,
    output logic [N_CH-1:0]       O_PWM,
    output logic                  O_period_tick,
    output logic                  O_update_ack
);

    localparam logic [CNT_W-1:0] DEF_PER = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);

    logic [N_CH-1:0][CNT_W-1:0] duty_in;
    assign duty_in = I_duty;

    // counters
    logic [PS_W-1:0]  ps_d, ps_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             down_d, down_q;

    // active config
    logic [CNT_W-1:0]           per_d, per_q;
    logic [PS_W-1:0]            pre_d, pre_q;
    logic [N_CH-1:0][CNT_W-1:0] duty_d, duty_q;
    pwm_mode_e                  mode_d, mode_q;
    logic [N_CH-1:0]            pol_d, pol_q;

    // pending (shadow) config
    logic [CNT_W-1:0]           pper_d, pper_q;
    logic [PS_W-1:0]            ppre_d, ppre_q;
    logic [N_CH-1:0][CNT_W-1:0] pduty_d, pduty_q;
    pwm_mode_e                  pmode_d, pmode_q;
    logic [N_CH-1:0]            ppol_d, ppol_q;
    logic                       pvld_d, pvld_q;

    logic tick_d, tick_q;
    logic ack_d, ack_q;

    logic             tick, boundary, apply;
    logic [CNT_W-1:0] cnt_nxt;
    logic             down_nxt;
    logic [CNT_W-1:0] cmp_idx;
    logic             force_off;

    always_comb begin
        cnt_nxt  = cnt_q;
        down_nxt = down_q;
        if (per_q == '0) begin
            cnt_nxt  = '0;
            down_nxt = 1'b0;
        end else if (mode_q == PWM_EDGE) begin
            cnt_nxt  = (cnt_q == per_q - CNT_ONE) ? '0 : cnt_q + CNT_ONE;
            down_nxt = 1'b0;
        end else if (!down_q) begin
            if (cnt_q == per_q - CNT_ONE) begin
                cnt_nxt  = per_q;
                down_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_nxt = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) down_nxt = 1'b0;
        end
    end

    always_comb begin
        ps_d    = ps_q;
        cnt_d   = cnt_q;
        down_d  = down_q;
        per_d   = per_q;
        pre_d   = pre_q;
        duty_d  = duty_q;
        mode_d  = mode_q;
        pol_d   = pol_q;
        pper_d  = pper_q;
        ppre_d  = ppre_q;
        pduty_d = pduty_q;
        pmode_d = pmode_q;
        ppol_d  = ppol_q;
        pvld_d  = pvld_q;

        tick     = I_en && (ps_q == pre_q);
        boundary = tick && (cnt_nxt == '0);
        apply    = pvld_q && (I_en ? boundary : 1'b1);

        if (!I_en) begin
            ps_d   = '0;
            cnt_d  = '0;
            down_d = 1'b0;
        end else if (tick) begin
            ps_d   = '0;
            cnt_d  = cnt_nxt;
            down_d = down_nxt;
        end else begin
            ps_d = ps_q + PS_ONE;
        end

        if (apply) begin
            per_d  = pper_q;
            pre_d  = ppre_q;
            duty_d = pduty_q;
            mode_d = pmode_q;
            pol_d  = ppol_q;
            pvld_d = 1'b0;
        end

        // A capture in the apply cycle lands after the copy, so it waits a period.
        if (I_update) begin
            pper_d  = I_period;
            ppre_d  = I_prescale;
            pduty_d = duty_in;
            pmode_d = pwm_mode_e'(I_center);
            ppol_d  = I_polarity;
            pvld_d  = 1'b1;
        end

        tick_d = boundary;
        ack_d  = apply;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            ps_q    <= '0;
            cnt_q   <= '0;
            down_q  <= 1'b0;
            per_q   <= DEF_PER;
            pre_q   <= '0;
            duty_q  <= '0;
            mode_q  <= PWM_EDGE;
            pol_q   <= '0;
            pper_q  <= '0;
            ppre_q  <= '0;
            pduty_q <= '0;
            pmode_q <= PWM_EDGE;
            ppol_q  <= '0;
            pvld_q  <= 1'b0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
            down_q  <= down_d;
            per_q   <= per_d;
            pre_q   <= pre_d;
            duty_q  <= duty_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            pper_q  <= pper_d;
            ppre_q  <= ppre_d;
            pduty_q <= pduty_d;
            pmode_q <= pmode_d;
            ppol_q  <= ppol_d;
            pvld_q  <= pvld_d;
            tick_q  <= tick_d;
            ack_q   <= ack_d;
        end
    end

    // On the way down the index is cnt-1, so the center pulse is exactly 2*duty
    // ticks wide and straddles the cnt=0 boundary symmetrically.
    always_comb begin
        cmp_idx   = (mode_q == PWM_CENTER && down_q) ? cnt_q - CNT_ONE : cnt_q;
        force_off = !I_en || (per_q == '0);
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_compare_ch #(.CNT_W(CNT_W)) u_ch (
            .I_clk  (I_clk),
            .I_rst  (I_rst),
            .I_idx  (cmp_idx),
            .I_duty (duty_q[k]),
            .I_pol  (pol_q[k]),
            .I_off  (force_off),
            .O_pwm  (O_PWM[k])
        );
    end

    assign O_period_tick = tick_q;
    assign O_update_ack  = ack_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: period-position model checked every cycle, plus directed scenarios.
module tb_pwm_multi_ch;

    logic        I_clk;
    logic        I_rst;
    logic        I_en;
    logic [7:0]  I_prescale;
    logic [7:0]  I_period;
    logic [31:0] I_duty;
    logic        I_center;
    logic [3:0]  I_polarity;
    logic        I_update;
    logic [3:0]  O_PWM;
    logic        O_period_tick;
    logic        O_update_ack;

    pwm_multi_ch dut (
        .I_clk         (I_clk),
        .I_rst         (I_rst),
        .I_en          (I_en),
        .I_prescale    (I_prescale),
        .I_period      (I_period),
        .I_duty        (I_duty),
        .I_center      (I_center),
        .I_polarity    (I_polarity),
        .I_update      (I_update),
        .O_PWM         (O_PWM),
        .O_period_tick (O_period_tick),
        .O_update_ack  (O_update_ack)
    );

    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: position within the period (0..len-1) and prescale phase
    int       m_P, m_pre, m_pos, m_ps;
    int       m_d[4];
    bit       m_center;
    bit [3:0] m_pol;
    int       p_P, p_pre;
    int       p_d[4];
    bit       p_center, m_pv;
    bit [3:0] p_pol;
    bit [3:0] exp_pwm;
    bit       exp_tick, exp_ack;

    task automatic m_reset();
        m_P = 100; m_pre = 0; m_pos = 0; m_ps = 0; m_center = 0; m_pol = '0;
        for (int k = 0; k < 4; k++) begin m_d[k] = 0; p_d[k] = 0; end
        p_P = 0; p_pre = 0; p_center = 0; p_pol = '0; m_pv = 0;
        exp_pwm = '0; exp_tick = 0; exp_ack = 0;
    endtask

    function automatic bit m_high(input int pos, input int d);
        if (m_P == 0) return 1'b0;
        if (!m_center) return pos < d;
        return (pos < d) || (pos >= 2 * m_P - d);
    endfunction

    task automatic m_step();
        bit [3:0] np;
        bit bnd, app;
        int len;
        bnd = 0;
        for (int k = 0; k < 4; k++) np[k] = (I_en && m_high(m_pos, m_d[k])) ^ m_pol[k];
        if (I_en) begin
            if (m_ps == m_pre) begin
                m_ps = 0;
                len = m_center ? 2 * m_P : m_P;
                m_pos++;
                if (m_P == 0 || m_pos >= len) begin m_pos = 0; bnd = 1; end
            end else begin
                m_ps++;
            end
            app = m_pv && bnd;
        end else begin
            m_pos = 0; m_ps = 0; app = m_pv;
        end
        exp_pwm = np; exp_tick = bnd; exp_ack = app;
        if (app) begin
            m_P = p_P; m_pre = p_pre; m_center = p_center; m_pol = p_pol;
            for (int k = 0; k < 4; k++) m_d[k] = p_d[k];
            m_pv = 0;
        end
        if (I_update) begin
            p_P = int'(I_period); p_pre = int'(I_prescale); p_center = I_center; p_pol = I_polarity;
            for (int k = 0; k < 4; k++) p_d[k] = int'(I_duty[k*8 +: 8]);
            m_pv = 1;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge I_clk);
            if (I_rst) m_reset();
            chk("pwm", int'(O_PWM), int'(exp_pwm));
            chk("tick", int'(O_period_tick), int'(exp_tick));
            chk("ack", int'(O_update_ack), int'(exp_ack));
            if (!I_rst) m_step();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    int hi[4];
    int nt, na, run, run1;

    task automatic win(input int n, input int upd_at);
        for (int k = 0; k < 4; k++) hi[k] = 0;
        nt = 0; na = 0; run = 0; run1 = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge I_clk); #1;
            I_update = (i == upd_at);
            @(negedge I_clk);
            for (int k = 0; k < 4; k++) if (O_PWM[k]) hi[k]++;
            if (O_PWM[1]) run++; else run = 0;
            if (run > run1) run1 = run;
            nt += int'(O_period_tick);
            na += int'(O_update_ack);
        end
    endtask

    task automatic cfg(input int per, input int pre, input bit ctr, input bit [3:0] pol,
                       input int d0, input int d1, input int d2, input int d3);
        @(posedge I_clk); #1;
        I_period = 8'(per); I_prescale = 8'(pre); I_center = ctr; I_polarity = pol;
        I_duty = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        I_update = 1'b1;
        @(posedge I_clk); #1;
        I_update = 1'b0;
    endtask

    task automatic wait_ack(input int bound);
        int n;
        n = 0;
        do begin @(negedge I_clk); n++; end while (!O_update_ack && n < bound);
        chk("ack_seen", int'(O_update_ack), 1);
    endtask

    task automatic cycles_to_tick(input int bound, output int n);
        n = 0;
        do begin @(negedge I_clk); n++; end while (!O_period_tick && n < bound);
    endtask

    int n;

    initial begin
        I_rst = 1'b0; I_en = 1'b0; I_prescale = '0; I_period = '0; I_duty = '0;
        I_center = 1'b0; I_polarity = '0; I_update = 1'b0;
        #2 I_rst = 1'b1;
        repeat (3) @(posedge I_clk);
        #1;
        chk("rst_pwm", int'(O_PWM), 0);
        chk("rst_tick", int'(O_period_tick), 0);
        chk("rst_ack", int'(O_update_ack), 0);
        I_rst = 1'b0;
        I_en  = 1'b1;

        // edge, P=100, duties {0,25,100,150}
        cfg(100, 0, 0, 4'b0000, 0, 25, 100, 150);
        wait_ack(300);
        chk("t2_ack_with_tick", int'(O_period_tick), 1);
        win(100, -1);
        chk("t2_ch0", hi[0], 0);
        chk("t2_ch1", hi[1], 25);
        chk("t2_ch2", hi[2], 100);
        chk("t2_ch3", hi[3], 100);
        chk("t2_ticks", nt, 1);

        // shadow update of ch1 to 50 mid-period
        I_duty = {8'd150, 8'd100, 8'd50, 8'd0};
        win(100, 40);
        chk("t3_cur_period", hi[1], 25);
        chk("t3_tick_end", int'(O_period_tick), 1);
        chk("t3_ack_end", int'(O_update_ack), 1);
        win(100, -1);
        chk("t3_next_period", hi[1], 50);

        // center, P=10
        cfg(10, 0, 1, 4'b0000, 0, 3, 10, 0);
        wait_ack(300);
        win(40, -1);
        chk("t4_ch1_high", hi[1], 12);
        chk("t4_ch1_run", run1, 6);
        chk("t4_ch2_const", hi[2], 40);
        chk("t4_ticks", nt, 2);

        // prescale 3, edge, P=10
        cfg(10, 3, 0, 4'b0000, 0, 5, 0, 0);
        wait_ack(300);
        win(40, -1);
        chk("t5_ch1_high", hi[1], 20);
        chk("t5_ticks", nt, 1);
        chk("t5_tick_end", int'(O_period_tick), 1);
        I_duty = {8'd0, 8'd0, 8'd8, 8'd0};
        win(40, 38);
        chk("t5_bnd_upd_no_ack", na, 0);
        chk("t5_bnd_tick", int'(O_period_tick), 1);
        win(40, -1);
        chk("t5_late_ack", na, 1);
        chk("t5_old_duty", hi[1], 20);
        win(40, -1);
        chk("t5_new_duty", hi[1], 32);

        // polarity and enable
        cfg(10, 0, 0, 4'b0010, 0, 5, 0, 0);
        wait_ack(300);
        win(10, -1);
        chk("t6_ch1_inv", hi[1], 5);
        chk("t6_ch0", hi[0], 0);
        repeat (3) @(posedge I_clk);
        #1;
        I_en = 1'b0;
        @(posedge I_clk);
        @(negedge I_clk);
        chk("t6_dis_pwm", int'(O_PWM), 2);
        win(20, -1);
        chk("t6_dis_ticks", nt, 0);
        chk("t6_dis_ch1", hi[1], 20);
        I_duty = {8'd0, 8'd0, 8'd3, 8'd0};
        win(3, 0);
        chk("t6_dis_ack", na, 1);
        chk("t6_dis_ack_ticks", nt, 0);
        @(posedge I_clk); #1;
        I_en = 1'b1;
        cycles_to_tick(100, n);
        chk("t6_restart", n, 11);
        win(10, -1);
        chk("t6_new_duty", hi[1], 7);

        // mid-run reset discards pending config
        @(posedge I_clk); #1;
        I_period = 8'd20; I_duty = {8'd7, 8'd7, 8'd7, 8'd7}; I_update = 1'b1;
        @(posedge I_clk); #1;
        I_update = 1'b0;
        I_rst = 1'b1;
        #1;
        chk("t1_pwm", int'(O_PWM), 0);
        chk("t1_tick", int'(O_period_tick), 0);
        chk("t1_ack", int'(O_update_ack), 0);
        repeat (2) @(posedge I_clk);
        #1;
        I_rst = 1'b0;
        cycles_to_tick(200, n);
        chk("t1_def_period", n, 101);
        chk("t1_no_ack", int'(O_update_ack), 0);
        chk("t1_pwm_low", int'(O_PWM), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
